// File: rtl/vga_axil_pkg.sv
// Shared types and helpers for the VGA AXI4-Lite to native register bridge.
// Contents:
//   resp_t, OKAY, SLVERR   AXI-Lite response codes
//   w_state_t              write FSM states (collect / issue / respond)
//   r_state_t              read FSM states (idle / issue / wait / respond)
//   axil2native_addr       byte address -> word address (drops BL low bits)
package vga_axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_ISSUE   = 2'd1,
    W_RESP    = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } r_state_t;

  // Callers truncate the result to their native address width, which
  // discards the address bits above the implemented word range.
  function automatic logic [63:0] axil2native_addr(input logic [63:0] addr,
                                                   input int bl);
    return addr >> bl;
  endfunction

endpackage

// File: rtl/vga_axil_hold_reg.sv
// One-entry valid/ready holding register.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in_data  upstream channel; in_ready is registered
//   accept_next   owner will be collecting in the next cycle
//   clear         drop the held entry (takes effect next cycle)
//   held_next     held flag as it will be after this edge
//   data          captured payload, stable while held
module vga_axil_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         accept_next,
  input  logic         clear,
  output logic         held_next,
  output logic [W-1:0] data
);

  logic held;
  logic fire;

  assign fire      = in_valid & in_ready;
  assign held_next = clear ? 1'b0 : (held | fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      held     <= held_next;
      // Ready is a flop, so it is computed from the state one cycle ahead.
      in_ready <= accept_next & ~held_next;
      if (fire) data <= in_data;
    end
  end

endmodule

// File: rtl/vga_axil_slave_native.sv
// AXI4-Lite slave to native register-port bridge for the VGA control block.
// AW and W are collected independently into one-entry buffers; the write is
// issued on the native port once both are held. Reads issue one read strobe
// and sample data_i READ_LATENCY cycles later. Both paths run concurrently.
//
// Handshake rule on every AXI channel: a transfer happens on a rising clk
// edge where valid and ready are both 1; a source keeps valid and payload
// steady until that edge, and this block never lowers valid (bvalid/rvalid)
// or changes the payload before its transfer.
//
// Ports: clk, rst (sync, active high); AW/W/B/AR/R AXI-Lite channels;
//   write_en_o/addr_write_o/data_o/strb_o native write port;
//   read_en_o/addr_read_o/data_i native read port;
//   w_state_dbg/r_state_dbg current write/read FSM state.
// Build option: VGA_AXIL_SLVERR_EN answers out-of-range or misaligned
//   requests with SLVERR and keeps them off the native port.
module vga_axil_slave_native
  import vga_axil_pkg::*;
#(
  parameter int AXIL_ADDR_W   = 32,
  parameter int DATA_W        = 32,
  parameter int NATIVE_ADDR_W = 4,
  parameter int READ_LATENCY  = 1,
  parameter int NUM_REGS      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXIL_ADDR_W-1:0]   awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [AXIL_ADDR_W-1:0]   araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic                     write_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_write_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [DATA_W/8-1:0]      strb_o,
  output logic                     read_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_read_o,
  input  logic [DATA_W-1:0]        data_i,
  output logic [1:0]               w_state_dbg,
  output logic [1:0]               r_state_dbg
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BL     = $clog2(STRB_W);
  // The wait counter runs from READ_LATENCY-1 down to 0 inclusive.
  localparam logic [2:0] RD_CNT_INIT =
    (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                     aw_held_next, w_held_next;
  logic                     w_accept_next, w_clear;
  logic [AXIL_ADDR_W-1:0]   aw_data;
  logic [DATA_W+STRB_W-1:0] w_data;
  logic [AXIL_ADDR_W-1:0]   ar_addr;
  logic [2:0]               rd_cnt;
  logic                     rd_sample;
  logic                     wr_err, rd_err;

  function automatic logic [NATIVE_ADDR_W-1:0] word_idx(
      input logic [AXIL_ADDR_W-1:0] a);
    return NATIVE_ADDR_W'(axil2native_addr(64'(a), BL));
  endfunction

`ifdef VGA_AXIL_SLVERR_EN
  function automatic logic addr_err(input logic [AXIL_ADDR_W-1:0] a);
    return (a[BL-1:0] != '0) || (32'(word_idx(a)) >= 32'(NUM_REGS));
  endfunction
  assign wr_err = addr_err(aw_data);
  assign rd_err = addr_err(ar_addr);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // ---------------- write path ----------------
  assign w_accept_next = (w_next == W_COLLECT);
  assign w_clear       = (w_state == W_RESP) & bready;

  vga_axil_hold_reg #(.W(AXIL_ADDR_W)) u_aw_hold (
    .clk(clk), .rst(rst),
    .in_valid(awvalid), .in_ready(awready), .in_data(awaddr),
    .accept_next(w_accept_next), .clear(w_clear),
    .held_next(aw_held_next), .data(aw_data)
  );

  vga_axil_hold_reg #(.W(DATA_W + STRB_W)) u_w_hold (
    .clk(clk), .rst(rst),
    .in_valid(wvalid), .in_ready(wready), .in_data({wdata, wstrb}),
    .accept_next(w_accept_next), .clear(w_clear),
    .held_next(w_held_next), .data(w_data)
  );

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_COLLECT;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_COLLECT: if (aw_held_next & w_held_next) w_next = W_ISSUE;
      W_ISSUE:   w_next = W_RESP;
      W_RESP:    if (bready) w_next = W_COLLECT;
      default:   w_next = W_COLLECT;
    endcase
  end

  assign write_en_o   = (w_state == W_ISSUE) & ~wr_err;
  assign addr_write_o = word_idx(aw_data);
  assign data_o       = w_data[DATA_W+STRB_W-1:STRB_W];
  assign strb_o       = w_data[STRB_W-1:0];
  assign bvalid       = (w_state == W_RESP);
  assign bresp        = (bvalid & wr_err) ? SLVERR : OKAY;
  assign w_state_dbg  = w_state;

  // ---------------- read path ----------------
  assign rd_sample = ((r_state == R_ISSUE) && (READ_LATENCY == 0)) ||
                     ((r_state == R_WAIT) && (rd_cnt == 3'd0));

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (arvalid & arready) r_next = R_ISSUE;
      R_ISSUE: r_next = (READ_LATENCY == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (rd_cnt == 3'd0) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      ar_addr <= '0;
      rd_cnt  <= 3'd0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      if (arvalid & arready) ar_addr <= araddr;
      if (r_state == R_ISSUE)     rd_cnt <= RD_CNT_INIT;
      else if (r_state == R_WAIT) rd_cnt <= rd_cnt - 3'd1;
      if (rd_sample) begin
        rdata <= rd_err ? '0 : data_i;
        rresp <= rd_err ? SLVERR : OKAY;
      end
    end
  end

  assign read_en_o   = (r_state == R_ISSUE) & ~rd_err;
  assign addr_read_o = word_idx(ar_addr);
  assign rvalid      = (r_state == R_RESP);
  assign r_state_dbg = r_state;

endmodule

// File: tb/tb_vga_axil_slave_native.sv
// Bench for vga_axil_slave_native: table vectors, hand-written corner
// sequences (reset during issue, stalled read with concurrent write, error
// responses) and randomized traffic against a word-array model.
module tb_vga_axil_slave_native;

  localparam int RL = 3;
`ifdef VGA_AXIL_SLVERR_EN
  localparam int NREGS     = 4;
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam int NREGS     = 16;
  localparam bit SLVERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, data_i = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp, w_state_dbg, r_state_dbg;
  logic [31:0] rdata, data_o;
  logic [3:0]  strb_o, addr_write_o, addr_read_o;
  logic        write_en_o, read_en_o;

  vga_axil_slave_native #(
    .AXIL_ADDR_W(32), .DATA_W(32), .NATIVE_ADDR_W(4),
    .READ_LATENCY(RL), .NUM_REGS(NREGS)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .write_en_o(write_en_o), .addr_write_o(addr_write_o),
    .data_o(data_o), .strb_o(strb_o),
    .read_en_o(read_en_o), .addr_read_o(addr_read_o), .data_i(data_i),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [39:0] wr_exp_q[$];   // {native addr, data, strb}
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];    // {resp, data}

  logic [31:0] ref_mem[16];   // model of the register file
  logic [31:0] nat_mem[16];   // register file behind the native port

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit req_err(input logic [31:0] a);
    return SLVERR_EN && (((a % 4) != 0) || (widx(a) >= NREGS));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- monitors / native responder ----------------
  initial forever begin
    @(negedge clk);
    if (write_en_o) begin
      nat_mem[addr_write_o] = merge(nat_mem[addr_write_o], data_o, strb_o);
      check("write_expected", 64'(wr_exp_q.size() > 0), 64'd1);
      if (wr_exp_q.size() > 0)
        check("native_write", {addr_write_o, data_o, strb_o},
              wr_exp_q.pop_front());
    end
    if (bvalid && bready) begin
      check("b_expected", 64'(b_exp_q.size() > 0), 64'd1);
      if (b_exp_q.size() > 0) check("bresp", bresp, b_exp_q.pop_front());
    end
    if (rvalid && rready) begin
      check("r_expected", 64'(r_exp_q.size() > 0), 64'd1);
      if (r_exp_q.size() > 0) check("rresp_rdata", {rresp, rdata},
                                    r_exp_q.pop_front());
    end
  end

  // Drives the stored word during exactly the cycle the bridge samples it.
  initial forever begin
    logic [31:0] val;
    @(negedge clk);
    if (read_en_o) begin
      val = nat_mem[addr_read_o];
      repeat (RL) @(posedge clk);
      #1 data_i = val;
      @(posedge clk);
      #1 data_i = $urandom;
    end else begin
      data_i = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly,
                          input logic [3:0] exp_naddr);
    bit err = req_err(a);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    if (!err) begin
      wr_exp_q.push_back({exp_naddr, d, s});
      ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, s);
    end
    b_exp_q.push_back(err ? 2'b10 : 2'b00);
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (c >= aw_dly);
      awaddr  = a;
      wvalid  = !w_done && (c >= w_dly);
      wdata   = d;
      wstrb   = s;
      @(negedge clk);
      if (w_done)  check("wready_while_held", wready, 0);
      if (aw_done) check("awready_while_held", awready, 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      aw_done |= aw_hs;
      w_done  |= w_hs;
      c++;
      if (c > 100) begin timeout("aw_w"); break; end
    end
    awvalid = 0;
    wvalid  = 0;
    @(negedge clk);
    check("write_en_issue", write_en_o, !err);
    if (!err) check("addr_write", addr_write_o, exp_naddr);
    check("bvalid_early", bvalid, 0);
    step();
    @(negedge clk);
    check("bvalid_rise", bvalid, 1);
    check("write_en_single", write_en_o, 0);
    step();
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      step();
    end
    bready = 1;
    c = 0;
    forever begin
      @(negedge clk);
      if (bvalid) break;
      step();
      if (++c > 50) begin timeout("b"); break; end
    end
    step();
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                         input int r_dly);
    bit err = req_err(a);
    bit done = 0;
    int c = 0;
    r_exp_q.push_back({err ? 2'b10 : 2'b00, exp_d});
    araddr  = a;
    arvalid = 1;
    while (!done) begin
      @(negedge clk);
      done = arready;
      step();
      if (++c > 100) begin timeout("ar"); break; end
    end
    arvalid = 0;
    @(negedge clk);
    check("read_en_issue", read_en_o, !err);
    if (!err) check("addr_read", addr_read_o, 64'(widx(a)));
    step();
    for (int k = 0; k < RL; k++) begin
      @(negedge clk);
      check("rvalid_early", rvalid, 0);
      check("read_en_single", read_en_o, 0);
      step();
    end
    @(negedge clk);
    check("rvalid_rise", rvalid, 1);
    step();
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, exp_d);
      step();
    end
    rready = 1;
    c = 0;
    forever begin
      @(negedge clk);
      if (rvalid) break;
      step();
      if (++c > 50) begin timeout("r"); break; end
    end
    step();
    rready = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [3:0]  exp_naddr;
    logic [31:0] exp_rdata;
    int          r_dly;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h08,  32'hDEADBEEF, 4'hF,    0, 0, 0, 4'd2, 32'hDEADBEEF, 0};
    vecs[1] = '{32'h0C,  32'hA5A5A5A5, 4'b0101, 3, 0, 1, 4'd3, 32'h00A500A5, 1};
    vecs[2] = '{32'h04,  32'h12345678, 4'hF,    0, 2, 3, 4'd1, 32'h12345678, 2};
    vecs[3] = '{32'h08,  32'h11223344, 4'b1000, 1, 1, 0, 4'd2, 32'h11ADBEEF, 0};
    vecs[4] = '{32'h00,  32'hCAFEF00D, 4'b0011, 2, 1, 0, 4'd0, 32'h0000F00D, 3};
    vecs[5] = '{32'h40C, 32'h0BADF00D, 4'hF,    0, 0, 2, 4'd3, 32'h0BADF00D, 1};
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      nat_mem[i] = '0;
    end

    // reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_write_en", write_en_o, 0);
    check("rst_read_en", read_en_o, 0);
    step();
    rst = 0;
    step();
    @(negedge clk);
    check("ready_after_rst", {awready, wready, arready}, 3'b111);
    step();

    // table vectors: write, then read back
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly,
               vecs[i].w_dly, vecs[i].b_dly, vecs[i].exp_naddr);
      do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].r_dly);
    end

    // reset while the write is in its issue cycle: that strobe still happens,
    // nothing after it does
    wr_exp_q.push_back({4'd0, 32'h55AA55AA, 4'hF});
    ref_mem[0] = 32'h55AA55AA;
    awaddr = 32'h00; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    rst = 1;
    @(negedge clk);
    check("issue_before_rst", write_en_o, 1);
    step();
    @(negedge clk);
    check("rst_kills_write_en", write_en_o, 0);
    check("rst_kills_bvalid", bvalid, 0);
    check("rst_readies_low", {awready, wready, arready}, 3'b000);
    step();
    rst = 0;
    step();
    @(negedge clk);
    check("readies_after_rst", {awready, wready, arready}, 3'b111);
    bready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check("no_bvalid_after_rst", bvalid, 0);
    end
    step();
    bready = 0;

    // stalled read response with a write completing underneath it
    fork
      do_read(32'h04, 32'h12345678, 10);
      begin
        repeat (4) step();
        do_write(32'h08, 32'h600DCAFE, 4'hF, 0, 0, 0, 4'd2);
      end
    join
    do_read(32'h08, 32'h600DCAFE, 0);

`ifdef VGA_AXIL_SLVERR_EN
    // out-of-range write and misaligned read
    do_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 4'd4);
    do_read(32'h02, 32'h0, 1);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 4'(widx(a)));
      else
        do_read(a, req_err(a) ? 32'h0 : ref_mem[widx(a)],
                $urandom_range(0, 3));
    end

    repeat (3) step();
    check("wr_queue_drained", wr_exp_q.size(), 0);
    check("b_queue_drained", b_exp_q.size(), 0);
    check("r_queue_drained", r_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_axil_slave_native.md
Name: vga_axil_slave_native

Overview:
- Parametrised AXI4-Lite slave to native register-port bridge for the VGA control block.
- Accepts AW and W independently, holding each in a one-entry buffer until its partner arrives.
- Forwards byte strobes and supports a configurable native read latency.
- Sits between the AXI-Lite interconnect and the VGA register file; read and write paths run concurrently.

Parameters:
- AXIL_ADDR_W, 32: AXI-Lite address width.
- DATA_W, 32: data width; 32 or 64.
- NATIVE_ADDR_W, 4: native word-address width; native addr = axil addr[NATIVE_ADDR_W+BL-1:BL], where BL = $clog2(DATA_W/8).
- READ_LATENCY, 1: cycles from read_en_o to valid data_i; range 0..7.
- NUM_REGS, 16: number of implemented word registers, 1..2**NATIVE_ADDR_W; used by the optional range check.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- awaddr  in  AXIL_ADDR_W; awvalid in 1; awready out 1.
- wdata  in  DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1.
- bresp  out  2; bvalid out 1; bready in 1.
- araddr  in  AXIL_ADDR_W; arvalid in 1; arready out 1.
- rdata  out  DATA_W; rresp out 2; rvalid out 1; rready in 1.
- write_en_o  out  1  one-cycle native write strobe.
- addr_write_o  out  NATIVE_ADDR_W  native write word address.
- data_o  out  DATA_W  native write data.
- strb_o  out  DATA_W/8  native byte enables.
- read_en_o  out  1  one-cycle native read strobe.
- addr_read_o  out  NATIVE_ADDR_W  native read word address.
- data_i  in  DATA_W  native read data.

Behaviour:
- Reset: all outputs registered, 0 while rst is high, including awready, wready and arready. Readies rise in the first cycle after rst falls. bresp/rresp reset to OKAY (2'b00).
- Reset mid-transaction: the transaction is abandoned. No write_en_o, read_en_o, bvalid or rvalid follows.
- Write FSM states: WCollect, WIssue, WResp.
  - WCollect: awready = !aw_held; wready = !w_held. An AW handshake captures addr and sets aw_held; a W handshake captures data/strb and sets w_held. Both may occur in the same cycle, in either order, or with any gap.
  - WCollect -> WIssue: in the cycle after both are held.
  - WIssue: write_en_o = 1 for exactly one cycle; addr/data/strb outputs valid and stable. awready and wready are 0.
  - WIssue -> WResp: next cycle. bvalid = 1 and is held until bready.
  - WResp -> WCollect: on B handshake; held flags clear.
  - Latency: simultaneous AW+W handshake at T gives write_en_o at T+1 and bvalid at T+2.
- Read FSM states: RIdle, RIssue, RWait, RResp.
  - RIdle: arready = 1. An AR handshake at T captures the address.
  - RIssue (T+1): read_en_o = 1 for one cycle.
  - data_i is sampled READ_LATENCY cycles after the RIssue cycle (READ_LATENCY = 0: sampled in the RIssue cycle). A 3-bit down-counter in RWait counts the wait.
  - RResp: rvalid = 1 from the cycle after the sample; rdata is stable until the R handshake, then back to RIdle.
- Read and write FSMs are fully independent; simultaneous read_en_o and write_en_o are legal.
- Backpressure: bready/rready held low indefinitely stalls only their own channel.
- Address bits below BL and above NATIVE_ADDR_W+BL-1 are ignored for native addressing.

Optional Feature:
- VGA_AXIL_SLVERR_EN defined: a request whose word index is >= NUM_REGS, or whose low BL address bits are nonzero, gets response SLVERR (2'b10).
  - Erroneous writes: write_en_o is suppressed; B timing is unchanged.
  - Erroneous reads: read_en_o is suppressed; rdata = 0; R timing is unchanged.
- Undefined: responses are always OKAY and all requests reach the native port.

Decomposition:
- Package vga_axil_pkg gains:
  - resp_t and OKAY/SLVERR constants.
  - Parametrised axil2native_addr function.
  - Write-state enum and read-state enum.
- Sub-module vga_axil_hold_reg: one-entry valid/ready holding register, instanced for AW and for W.

Test Plan:
- Simultaneous AW+W, awaddr=0x08, wdata=0xDEADBEEF, wstrb=4'hF at T -> write_en_o@T+1 with addr_write_o=2, data_o=0xDEADBEEF; bvalid@T+2, bresp=OKAY.
- W at T, AW at T+3 (awaddr=0x0C, wstrb=4'b0101) -> wready=0 at T+1..T+3; write_en_o@T+4 with addr=3, strb_o=4'b0101.
- READ_LATENCY=3, araddr=0x04 at T, data_i=0x12345678 at T+4 -> read_en_o@T+1, addr_read_o=1, rvalid@T+5, rdata=0x12345678.
- rready held low 10 cycles, then concurrent write -> rvalid and rdata stable throughout; write completes unaffected.
- rst asserted at the WIssue cycle -> write_en_o=0 from the next cycle, no bvalid; readies=1 one cycle after rst falls.
- VGA_AXIL_SLVERR_EN, NUM_REGS=4, awaddr=0x10 -> no write_en_o, bresp=SLVERR; araddr=0x02 -> rresp=SLVERR, rdata=0.
